// File: rtl/peak_rv32im_opfetch.sv
// -----------------------------------------------------------------------------
// peak_rv32im_opfetch
//
// Operand fetch stage sitting between decode and execute. Two entries:
//   S1 - instruction whose register file read is in flight (one-cycle latency)
//   S2 - output register that drives OUT_* towards execute
// A writeback landing while an instruction waits in S1 is captured into a
// per-operand forward register, so the operand handed to execute reflects
// every write that happened before the S1 -> S2 transfer edge.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   TASKNUM                  task tag attached to each accepted instruction
//   IN_VALID / IN_READY      decode-side handshake
//   IN_PC, IN_INST           instruction sideband, passed through untouched
//   IN_RS1ADDR, IN_RS2ADDR   source register indices of the incoming instr
//   RS1ADDR, RS2ADDR         read addresses to the register file
//   RS1, RS2                 register file read data (one cycle after address)
//   WB_WE/WB_TASK/WB_ADDR/WB_DATA  writeback seen by the register file
//   AR_EN                    debug access owns register file port 1
//   FLUSH                    drop everything in flight
//   OUT_VALID / OUT_READY    execute-side handshake
//   OUT_PC, OUT_INST, OUT_RS1, OUT_RS2  sideband and resolved operands
// -----------------------------------------------------------------------------
module peak_rv32im_opfetch (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TASKNUM,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_PC,
    input  logic [31:0] IN_INST,
    input  logic [4:0]  IN_RS1ADDR,
    input  logic [4:0]  IN_RS2ADDR,
    output logic [4:0]  RS1ADDR,
    output logic [4:0]  RS2ADDR,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    input  logic        WB_WE,
    input  logic        WB_TASK,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    input  logic        AR_EN,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_INST,
    output logic [31:0] OUT_RS1,
    output logic [31:0] OUT_RS2
);

    logic        s1_valid;
    logic [31:0] s1_pc;
    logic [31:0] s1_inst;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic        s1_task;
    logic        ar_dly;

    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;

    logic        s1_advance;
    logic        s1_hold;
    logic        accept;
    logic        tag_task;
    logic        wb_hit1;
    logic        wb_hit2;
    logic [31:0] op1_next;
    logic [31:0] op2_next;

    // Handshake and read-address steering. While S1 holds, its indices are
    // re-presented every cycle so the register file keeps returning fresh
    // data; on an accept the new instruction's indices go out instead. A
    // writeback matches against whichever instruction will occupy S1 after
    // this edge, which is why the tag/index come through the same mux.
    always_comb begin
        s1_advance = s1_valid && (!OUT_VALID || OUT_READY) && !AR_EN && !ar_dly && !FLUSH;
        IN_READY   = (!s1_valid || s1_advance) && !AR_EN && !FLUSH;
        accept     = IN_VALID && IN_READY;
        s1_hold    = s1_valid && !s1_advance;
        RS1ADDR    = accept ? IN_RS1ADDR : s1_rs1;
        RS2ADDR    = accept ? IN_RS2ADDR : s1_rs2;
        tag_task   = accept ? TASKNUM : s1_task;
        wb_hit1    = WB_WE && (WB_ADDR == RS1ADDR) && (WB_TASK == tag_task) && (RS1ADDR != 5'd0);
        wb_hit2    = WB_WE && (WB_ADDR == RS2ADDR) && (WB_TASK == tag_task) && (RS2ADDR != 5'd0);
        op1_next   = (s1_rs1 == 5'd0) ? 32'd0 : (fwd1_valid ? fwd1_data : RS1);
        op2_next   = (s1_rs2 == 5'd0) ? 32'd0 : (fwd2_valid ? fwd2_data : RS2);
    end

    // AR_EN delayed by one cycle: the first read after debug releases port 1
    // returns a cycle later, so S1 must not advance on the debug data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ar_dly <= 1'b0;
        end else begin
            ar_dly <= AR_EN;
        end
    end

    // S1: load on accept (which may coincide with an advance), empty on a
    // bare advance. FLUSH wins over everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_pc    <= 32'd0;
            s1_inst  <= 32'd0;
            s1_rs1   <= 5'd0;
            s1_rs2   <= 5'd0;
            s1_task  <= 1'b0;
        end else if (FLUSH) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pc    <= IN_PC;
            s1_inst  <= IN_INST;
            s1_rs1   <= IN_RS1ADDR;
            s1_rs2   <= IN_RS2ADDR;
            s1_task  <= TASKNUM;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Forward registers. A fresh capture starts from the hit of this edge;
    // while held, a hit refreshes the data and a miss keeps what was caught
    // earlier (the register file read already misses the same-edge write).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd1_valid <= 1'b0;
            fwd1_data  <= 32'd0;
            fwd2_valid <= 1'b0;
            fwd2_data  <= 32'd0;
        end else if (FLUSH) begin
            fwd1_valid <= 1'b0;
            fwd2_valid <= 1'b0;
        end else if (accept || s1_hold) begin
            if (wb_hit1) begin
                fwd1_valid <= 1'b1;
                fwd1_data  <= WB_DATA;
            end else if (accept) begin
                fwd1_valid <= 1'b0;
            end
            if (wb_hit2) begin
                fwd2_valid <= 1'b1;
                fwd2_data  <= WB_DATA;
            end else if (accept) begin
                fwd2_valid <= 1'b0;
            end
        end
    end

    // S2 output register: loads on advance, otherwise holds its payload;
    // valid drops once execute takes the entry and nothing replaces it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_PC    <= 32'd0;
            OUT_INST  <= 32'd0;
            OUT_RS1   <= 32'd0;
            OUT_RS2   <= 32'd0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (s1_advance) begin
            OUT_VALID <= 1'b1;
            OUT_PC    <= s1_pc;
            OUT_INST  <= s1_inst;
            OUT_RS1   <= op1_next;
            OUT_RS2   <= op2_next;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peak_rv32im_opfetch.sv
// -----------------------------------------------------------------------------
// tb_peak_rv32im_opfetch
//
// Drives the operand fetch stage with directed sequences and random traffic.
// The bench owns a simple two-bank register file (read-before-write, one
// cycle latency, read bank chosen by TASKNUM) and a scoreboard: every
// accepted instruction is queued, and when a new entry shows up on OUT_* its
// operands must equal the register file contents as they stood just before
// the transfer edge (x0 always reads 0).
// -----------------------------------------------------------------------------
module tb_peak_rv32im_opfetch;

    logic        CLK;
    logic        RST;
    logic        TASKNUM;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_PC;
    logic [31:0] IN_INST;
    logic [4:0]  IN_RS1ADDR;
    logic [4:0]  IN_RS2ADDR;
    logic [4:0]  RS1ADDR;
    logic [4:0]  RS2ADDR;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic        WB_WE;
    logic        WB_TASK;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        AR_EN;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INST;
    logic [31:0] OUT_RS1;
    logic [31:0] OUT_RS2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        tsk;
    } item_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
    } out_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [4:0]  r1;
        logic        ordy;
        logic        exp_ov;
        logic [31:0] exp_pc;
        logic [31:0] exp_op1;
    } vec_t;

    logic [31:0] rf [2][32];
    item_t       q[$];
    out_t        curExp;
    vec_t        vecs[6];
    int          total;
    int          bad;
    int          arLeft;

    peak_rv32im_opfetch dut (
        .CLK        (CLK),
        .RST        (RST),
        .TASKNUM    (TASKNUM),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_PC      (IN_PC),
        .IN_INST    (IN_INST),
        .IN_RS1ADDR (IN_RS1ADDR),
        .IN_RS2ADDR (IN_RS2ADDR),
        .RS1ADDR    (RS1ADDR),
        .RS2ADDR    (RS2ADDR),
        .RS1        (RS1),
        .RS2        (RS2),
        .WB_WE      (WB_WE),
        .WB_TASK    (WB_TASK),
        .WB_ADDR    (WB_ADDR),
        .WB_DATA    (WB_DATA),
        .AR_EN      (AR_EN),
        .FLUSH      (FLUSH),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_PC     (OUT_PC),
        .OUT_INST   (OUT_INST),
        .OUT_RS1    (OUT_RS1),
        .OUT_RS2    (OUT_RS2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: snapshot what the DUT sees before the edge, let the
    // edge happen, update the scoreboard, then advance the register file
    // model (read-before-write) and present its read data.
    task automatic stepCycle();
        logic        acc, par, pbank, pwe, pwt, pfl, pov, por, newItem;
        logic [4:0]  pa1, pa2, pwa;
        logic [31:0] pwd, rd1, rd2;
        item_t       it, hd;
        #1;
        acc   = IN_VALID && IN_READY;
        it    = '{pc: IN_PC, inst: IN_INST, r1: IN_RS1ADDR, r2: IN_RS2ADDR, tsk: TASKNUM};
        pa1   = RS1ADDR;
        pa2   = RS2ADDR;
        par   = AR_EN;
        pbank = TASKNUM;
        pwe   = WB_WE;
        pwt   = WB_TASK;
        pwa   = WB_ADDR;
        pwd   = WB_DATA;
        pfl   = FLUSH;
        pov   = OUT_VALID;
        por   = OUT_READY;
        @(posedge CLK);
        #1;
        if (pfl) begin
            q.delete();
            checkBit("flush_out_valid", OUT_VALID, 1'b0);
        end else begin
            newItem = OUT_VALID && (!pov || por);
            if (newItem) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious_output: got pc 0x%08h expected no entry", OUT_PC);
                end else begin
                    hd = q.pop_front();
                    curExp.pc   = hd.pc;
                    curExp.inst = hd.inst;
                    curExp.op1  = (hd.r1 == 5'd0) ? 32'd0 : rf[hd.tsk][hd.r1];
                    curExp.op2  = (hd.r2 == 5'd0) ? 32'd0 : rf[hd.tsk][hd.r2];
                end
            end else if (pov && !por) begin
                checkBit("hold_valid", OUT_VALID, 1'b1);
            end
            if (OUT_VALID) begin
                checkVal("out_pc", OUT_PC, curExp.pc);
                checkVal("out_inst", OUT_INST, curExp.inst);
                checkVal("out_rs1", OUT_RS1, curExp.op1);
                checkVal("out_rs2", OUT_RS2, curExp.op2);
            end
            if (acc) q.push_back(it);
        end
        rd1 = par ? $urandom() : rf[pbank][pa1];
        rd2 = rf[pbank][pa2];
        if (pwe) rf[pwt][pwa] = pwd;
        RS1 = rd1;
        RS2 = rd2;
    endtask

    task automatic applyStimulus(input vec_t v);
        IN_VALID   = v.iv;
        IN_PC      = v.pc;
        IN_INST    = 32'h0000_0013 | v.pc;
        IN_RS1ADDR = v.r1;
        IN_RS2ADDR = 5'd0;
        OUT_READY  = v.ordy;
        #1;
        checkBit("vec_in_ready", IN_READY, 1'b1);
    endtask

    task automatic checkOutput(input vec_t v);
        checkBit("vec_out_valid", OUT_VALID, v.exp_ov);
        if (v.exp_ov) begin
            checkVal("vec_out_pc", OUT_PC, v.exp_pc);
            checkVal("vec_out_rs1", OUT_RS1, v.exp_op1);
        end
    endtask

    // Empty the pipe and confirm nothing accepted got lost on the way.
    task automatic drain();
        IN_VALID  = 1'b0;
        AR_EN     = 1'b0;
        FLUSH     = 1'b0;
        WB_WE     = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) stepCycle();
        checkVal("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic writeReg(input logic tsk, input logic [4:0] addr, input logic [31:0] data);
        IN_VALID = 1'b0;
        WB_WE    = 1'b1;
        WB_TASK  = tsk;
        WB_ADDR  = addr;
        WB_DATA  = data;
        stepCycle();
        WB_WE    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        arLeft = 0;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 32; i++) rf[t][i] = 32'h11 * i;
            rf[t][0] = 32'hDEAD_0000;
            rf[t][5] = 32'h0000_AAAA;
        end
        curExp = '{pc: 32'd0, inst: 32'd0, op1: 32'd0, op2: 32'd0};

        vecs[0] = '{1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h00};
        vecs[1] = '{1'b1, 32'h4, 5'd2, 1'b1, 1'b1, 32'h0, 32'h11};
        vecs[2] = '{1'b1, 32'h8, 5'd3, 1'b1, 1'b1, 32'h4, 32'h22};
        vecs[3] = '{1'b1, 32'hC, 5'd4, 1'b1, 1'b1, 32'h8, 32'h33};
        vecs[4] = '{1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 32'hC, 32'h44};
        vecs[5] = '{1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h00};

        RST = 1'b1; TASKNUM = 1'b0; IN_VALID = 1'b0; IN_PC = 32'd0; IN_INST = 32'd0;
        IN_RS1ADDR = 5'd0; IN_RS2ADDR = 5'd0; RS1 = 32'd0; RS2 = 32'd0;
        WB_WE = 1'b0; WB_TASK = 1'b0; WB_ADDR = 5'd0; WB_DATA = 32'd0;
        AR_EN = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;

        // Reset state
        #3;
        checkBit("reset_out_valid", OUT_VALID, 1'b0);
        checkVal("reset_out_pc", OUT_PC, 32'd0);
        checkVal("reset_out_rs1", OUT_RS1, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checkBit("reset_in_ready", IN_READY, 1'b1);

        // Back-to-back streaming, one instruction per cycle
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput(vecs[i]);
        end

        // Stall with both entries full, then release
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INST = 32'h0000_0033; IN_RS2ADDR = 5'd0;
        IN_PC = 32'h100; IN_RS1ADDR = 5'd6; #1; stepCycle();
        IN_PC = 32'h104; IN_RS1ADDR = 5'd7; #1; stepCycle();
        IN_PC = 32'h108; IN_RS1ADDR = 5'd8;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkBit("stall_in_ready", IN_READY, 1'b0);
            checkVal("stall_rs1addr", 32'(RS1ADDR), 32'd7);
            stepCycle();
            checkVal("stall_out_pc", OUT_PC, 32'h100);
        end
        OUT_READY = 1'b1; #1;
        checkBit("release_in_ready", IN_READY, 1'b1);
        stepCycle();
        checkBit("release_valid", OUT_VALID, 1'b1);
        checkVal("release_pc", OUT_PC, 32'h104);
        IN_VALID = 1'b0; #1; stepCycle();
        checkBit("release_next_valid", OUT_VALID, 1'b1);
        checkVal("release_next_pc", OUT_PC, 32'h108);
        drain();

        // Forwarding: write on the accept edge
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN_PC = 32'h200; IN_RS1ADDR = 5'd0; IN_RS2ADDR = 5'd5;
        WB_WE = 1'b1; WB_TASK = 1'b0; WB_ADDR = 5'd5; WB_DATA = 32'h1234; #1; stepCycle();
        IN_VALID = 1'b0; WB_WE = 1'b0; #1; stepCycle();
        checkBit("fwd_accept_valid", OUT_VALID, 1'b1);
        checkVal("fwd_accept_rs2", OUT_RS2, 32'h1234);
        writeReg(1'b0, 5'd5, 32'h0000_AAAA);
        drain();

        // Forwarding: write two edges after accept while stalled
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_PC = 32'h210; IN_RS2ADDR = 5'd0; #1; stepCycle();
        IN_PC = 32'h214; IN_RS2ADDR = 5'd5; #1; stepCycle();
        IN_VALID = 1'b0; #1; stepCycle();
        writeReg(1'b0, 5'd5, 32'h1234);
        #1; stepCycle();
        OUT_READY = 1'b1; #1; stepCycle();
        checkVal("fwd_stall_pc", OUT_PC, 32'h214);
        checkVal("fwd_stall_rs2", OUT_RS2, 32'h1234);
        writeReg(1'b0, 5'd5, 32'h0000_AAAA);
        drain();

        // Forwarding: a write from the other task must not be picked up
        IN_VALID = 1'b1; IN_PC = 32'h220; IN_RS2ADDR = 5'd5;
        WB_WE = 1'b1; WB_TASK = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'h1234; #1; stepCycle();
        IN_VALID = 1'b0; WB_WE = 1'b0; #1; stepCycle();
        checkVal("fwd_other_task_rs2", OUT_RS2, 32'h0000_AAAA);
        drain();

        // x0 always reads zero, even with a write aimed at it
        IN_VALID = 1'b1; IN_PC = 32'h230; IN_RS1ADDR = 5'd0; IN_RS2ADDR = 5'd1;
        WB_WE = 1'b1; WB_TASK = 1'b0; WB_ADDR = 5'd0; WB_DATA = 32'hFFFF_FFFF; #1; stepCycle();
        IN_VALID = 1'b0; WB_WE = 1'b0; #1; stepCycle();
        checkVal("x0_rs1", OUT_RS1, 32'd0);
        checkVal("x0_rs2_x1", OUT_RS2, 32'h11);
        drain();

        // Debug access: S1 frozen during AR_EN and one cycle after
        IN_VALID = 1'b1; IN_PC = 32'h300; IN_RS1ADDR = 5'd3; IN_RS2ADDR = 5'd4; #1; stepCycle();
        IN_VALID = 1'b0; AR_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkBit("ar_in_ready", IN_READY, 1'b0);
            stepCycle();
            checkBit("ar_no_advance", OUT_VALID, 1'b0);
        end
        AR_EN = 1'b0; #1; stepCycle();
        checkBit("ar_dly_no_advance", OUT_VALID, 1'b0);
        #1; stepCycle();
        checkBit("ar_advance", OUT_VALID, 1'b1);
        checkVal("ar_pc", OUT_PC, 32'h300);
        checkVal("ar_rs1", OUT_RS1, 32'h33);
        drain();

        // Flush with both entries full, then a normal instruction
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_PC = 32'h310; #1; stepCycle();
        IN_PC = 32'h314; #1; stepCycle();
        IN_PC = 32'h318; FLUSH = 1'b1; #1;
        checkBit("flush_in_ready", IN_READY, 1'b0);
        stepCycle();
        checkBit("flush_clears", OUT_VALID, 1'b0);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; #1; stepCycle();
        checkBit("flush_s1_cleared", OUT_VALID, 1'b0);
        IN_VALID = 1'b1; IN_PC = 32'h400; IN_RS1ADDR = 5'd2; #1; stepCycle();
        IN_VALID = 1'b0; #1; stepCycle();
        checkBit("post_flush_valid", OUT_VALID, 1'b1);
        checkVal("post_flush_pc", OUT_PC, 32'h400);
        checkVal("post_flush_rs1", OUT_RS1, 32'h22);
        drain();

        // Random traffic, once per task tag
        for (int run = 0; run < 2; run++) begin
            TASKNUM = run[0];
            for (int c = 0; c < 300; c++) begin
                IN_VALID   = ($urandom_range(9) < 7);
                IN_PC      = $urandom();
                IN_INST    = $urandom();
                IN_RS1ADDR = 5'($urandom_range(7));
                IN_RS2ADDR = 5'($urandom_range(7));
                OUT_READY  = ($urandom_range(9) < 7);
                if (arLeft > 0) begin
                    AR_EN = 1'b1;
                    arLeft--;
                end else if ($urandom_range(29) == 0) begin
                    AR_EN = 1'b1;
                    arLeft = int'($urandom_range(3));
                end else begin
                    AR_EN = 1'b0;
                end
                FLUSH   = ($urandom_range(49) == 0);
                WB_WE   = 1'($urandom_range(1));
                WB_TASK = 1'($urandom_range(1));
                WB_ADDR = 5'($urandom_range(7));
                WB_DATA = $urandom();
                #1;
                if (AR_EN || FLUSH) checkBit("rand_ready_blocked", IN_READY, 1'b0);
                stepCycle();
            end
            arLeft = 0;
            drain();
        end

        // Reset mid-stream with both entries full: outputs clear without an edge
        TASKNUM = 1'b0;
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_PC = 32'h500; IN_INST = 32'h1111_0013;
        IN_RS1ADDR = 5'd1; IN_RS2ADDR = 5'd2; #1; stepCycle();
        IN_PC = 32'h504; #1; stepCycle();
        checkBit("pre_rst_valid", OUT_VALID, 1'b1);
        IN_VALID = 1'b0; #1;
        RST = 1'b1; #1;
        checkBit("rst_out_valid", OUT_VALID, 1'b0);
        checkVal("rst_out_pc", OUT_PC, 32'd0);
        checkVal("rst_out_inst", OUT_INST, 32'd0);
        checkVal("rst_out_rs1", OUT_RS1, 32'd0);
        checkVal("rst_out_rs2", OUT_RS2, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q.delete();
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkBit("post_rst_in_ready", IN_READY, 1'b1);
            stepCycle();
            checkBit("post_rst_no_out", OUT_VALID, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
